// File: rtl/timer_pkg.sv
// Shared definitions for the BCD countdown timer: FSM encoding, digit limits
// and a single-digit BCD decrement helper.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] BCD_MAX   = 4'd9;
  localparam logic [3:0] SEC_T_MAX = 4'd5;

  // Decrement one BCD digit, wrapping from 0 to the given top value.
  function automatic logic [3:0] dec_digit(input logic [3:0] d, input logic [3:0] wrap);
    return (d == 4'd0) ? wrap : d - 4'd1;
  endfunction

endpackage

// File: rtl/c60_down.sv
// Mod-60 BCD down-counter for the seconds stage; bo flags the 00 -> 59 wrap
// so the minutes stage can borrow in the same cycle.
module c60_down
  import timer_pkg::*;
(
  input  logic       clk,
  input  logic       cr,
  input  logic       en,
  input  logic       ld,
  input  logic [3:0] d_t,
  input  logic [3:0] d_u,
  output logic [3:0] bcd_t,
  output logic [3:0] bcd_u,
  output logic       bo
);

  logic [3:0] bcd_t_reg;
  logic [3:0] bcd_u_reg;

  always_ff @(posedge clk) begin
    if (!cr) begin
      bcd_t_reg <= 4'd0;
      bcd_u_reg <= 4'd0;
    end else if (ld) begin
      bcd_t_reg <= d_t;
      bcd_u_reg <= d_u;
    end else if (en) begin
      bcd_u_reg <= dec_digit(bcd_u_reg, BCD_MAX);
      if (bcd_u_reg == 4'd0)
        bcd_t_reg <= dec_digit(bcd_t_reg, SEC_T_MAX);
    end
  end

  assign bcd_t = bcd_t_reg;
  assign bcd_u = bcd_u_reg;
  assign bo    = en & (bcd_t_reg == 4'd0) & (bcd_u_reg == 4'd0);

endmodule

// File: rtl/bcd_down60_timer.sv
// Loadable MM:SS BCD countdown timer with start/pause control, done pulse,
// preset-error pulse and optional auto-reload of the last accepted preset.
module bcd_down60_timer
  import timer_pkg::*;
#(
  parameter logic [3:0] MIN_T_MAX   = 4'd9,
  parameter bit         AUTO_RELOAD = 1'b0
) (
  input  logic       clk,
  input  logic       cr,
  input  logic       tick,
  input  logic       load,
  input  logic       start,
  input  logic       pause,
  input  logic [3:0] pre_m_t,
  input  logic [3:0] pre_m_u,
  input  logic [3:0] pre_s_t,
  input  logic [3:0] pre_s_u,
  output logic [3:0] bcd_m_t,
  output logic [3:0] bcd_m_u,
  output logic [3:0] bcd_s_t,
  output logic [3:0] bcd_s_u,
  output logic       running,
  output logic       done,
  output logic       load_err
);

  state_t     state_reg, state_next;
  logic [3:0] m_t_reg, m_u_reg;
  logic       done_reg, done_next;
  logic       load_err_reg, load_err_next;
  logic [3:0] saved_reg [4];

  // Digit order everywhere: m_t, m_u, s_t, s_u.
  logic [3:0] pre_dig [4];
  logic [3:0] dig_max [4];
  logic [3:0] ld_dig  [4];
  logic [3:0] dig_ok;

  logic       ld_cnt, ld_from_saved, save_en, dec_en;
  logic       sec_bo, count_zero, count_one, saved_zero, preset_ok;
  logic [3:0] s_t, s_u;

  assign pre_dig = '{pre_m_t, pre_m_u, pre_s_t, pre_s_u};
  assign dig_max = '{MIN_T_MAX, BCD_MAX, SEC_T_MAX, BCD_MAX};

  for (genvar gi = 0; gi < 4; gi++) begin : g_digit
    assign dig_ok[gi] = (pre_dig[gi] <= dig_max[gi]);
    assign ld_dig[gi] = ld_from_saved ? saved_reg[gi] : pre_dig[gi];

    always_ff @(posedge clk) begin
      if (!cr)
        saved_reg[gi] <= 4'd0;
      else if (save_en)
        saved_reg[gi] <= pre_dig[gi];
    end
  end

  assign preset_ok  = &dig_ok;
  assign count_zero = (m_t_reg == 4'd0) && (m_u_reg == 4'd0) && (s_t == 4'd0) && (s_u == 4'd0);
  assign count_one  = (m_t_reg == 4'd0) && (m_u_reg == 4'd0) && (s_t == 4'd0) && (s_u == 4'd1);
  assign saved_zero = ((saved_reg[0] | saved_reg[1] | saved_reg[2] | saved_reg[3]) == 4'd0);

  c60_down u_sec (
    .clk   (clk),
    .cr    (cr),
    .en    (dec_en),
    .ld    (ld_cnt),
    .d_t   (ld_dig[2]),
    .d_u   (ld_dig[3]),
    .bcd_t (s_t),
    .bcd_u (s_u),
    .bo    (sec_bo)
  );

  always_comb begin
    state_next    = state_reg;
    ld_cnt        = 1'b0;
    ld_from_saved = 1'b0;
    save_en       = 1'b0;
    dec_en        = 1'b0;
    done_next     = 1'b0;
    load_err_next = 1'b0;
    case (state_reg)
      ST_RUN: begin
        // Load and start are meaningless while counting; pause outranks tick.
        if (pause) begin
          state_next = ST_PAUSE;
        end else if (tick) begin
          dec_en = 1'b1;
          if (count_one) begin
            state_next = ST_DONE;
            done_next  = 1'b1;
          end
        end
      end
      default: begin
        if (load) begin
          if (preset_ok) begin
            ld_cnt     = 1'b1;
            save_en    = 1'b1;
            state_next = ST_IDLE;
          end else begin
            load_err_next = 1'b1;
          end
        end else if (state_reg != ST_DONE) begin
          if (start && !count_zero)
            state_next = ST_RUN;
        end else if (AUTO_RELOAD && !saved_zero) begin
          ld_cnt        = 1'b1;
          ld_from_saved = 1'b1;
          state_next    = ST_RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!cr) begin
      state_reg    <= ST_IDLE;
      m_t_reg      <= 4'd0;
      m_u_reg      <= 4'd0;
      done_reg     <= 1'b0;
      load_err_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      done_reg     <= done_next;
      load_err_reg <= load_err_next;
      if (ld_cnt) begin
        m_t_reg <= ld_dig[0];
        m_u_reg <= ld_dig[1];
      end else if (sec_bo) begin
        // Zero is caught before the count can reach it, so minutes never underflow.
        m_u_reg <= dec_digit(m_u_reg, BCD_MAX);
        if (m_u_reg == 4'd0)
          m_t_reg <= dec_digit(m_t_reg, BCD_MAX);
      end
    end
  end

  assign bcd_m_t  = m_t_reg;
  assign bcd_m_u  = m_u_reg;
  assign bcd_s_t  = s_t;
  assign bcd_s_u  = s_u;
  assign running  = (state_reg == ST_RUN);
  assign done     = done_reg;
  assign load_err = load_err_reg;

endmodule

// File: tb/tb_bcd_down60_timer.sv
// Scoreboard bench: two timers (plain, and auto-reload with minutes-tens limit 5)
// share random stimulus and are checked against a seconds-total reference model.
module tb_bcd_down60_timer;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       cr = 1'b0, tick = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0;
  logic [3:0] pre_m_t = 4'd0, pre_m_u = 4'd0, pre_s_t = 4'd0, pre_s_u = 4'd0;

  logic [3:0] mt0, mu0, st0, su0, mt1, mu1, st1, su1;
  logic       run0, done0, lerr0, run1, done1, lerr1;

  bcd_down60_timer #(.MIN_T_MAX(4'd9), .AUTO_RELOAD(1'b0)) dut0 (
    .clk(clk), .cr(cr), .tick(tick), .load(load), .start(start), .pause(pause),
    .pre_m_t(pre_m_t), .pre_m_u(pre_m_u), .pre_s_t(pre_s_t), .pre_s_u(pre_s_u),
    .bcd_m_t(mt0), .bcd_m_u(mu0), .bcd_s_t(st0), .bcd_s_u(su0),
    .running(run0), .done(done0), .load_err(lerr0)
  );

  bcd_down60_timer #(.MIN_T_MAX(4'd5), .AUTO_RELOAD(1'b1)) dut1 (
    .clk(clk), .cr(cr), .tick(tick), .load(load), .start(start), .pause(pause),
    .pre_m_t(pre_m_t), .pre_m_u(pre_m_u), .pre_s_t(pre_s_t), .pre_s_u(pre_s_u),
    .bcd_m_t(mt1), .bcd_m_u(mu1), .bcd_s_t(st1), .bcd_s_u(su1),
    .running(run1), .done(done1), .load_err(lerr1)
  );

  typedef struct packed {
    logic [3:0] mt, mu, st, su;
    logic       run, done, lerr;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   checks = 0;
  int   failures = 0;
  int   txn = 0;

  // Reference model: count is a plain number of seconds.
  int ms[2]     = '{M_IDLE, M_IDLE};
  int mcnt[2]   = '{0, 0};
  int msaved[2] = '{0, 0};
  int mmax[2]   = '{9, 5};
  bit mauto[2]  = '{1'b0, 1'b1};

  task automatic step_model(input int k, output exp_t e);
    bit d, le, legal;
    int preset, mins, secs;
    d  = 1'b0;
    le = 1'b0;
    legal = (int'(pre_s_u) <= 9) && (int'(pre_s_t) <= 5) &&
            (int'(pre_m_u) <= 9) && (int'(pre_m_t) <= mmax[k]);
    preset = (int'(pre_m_t) * 10 + int'(pre_m_u)) * 60 + int'(pre_s_t) * 10 + int'(pre_s_u);
    if (!cr) begin
      ms[k] = M_IDLE; mcnt[k] = 0; msaved[k] = 0;
    end else if (ms[k] == M_RUN) begin
      if (pause) ms[k] = M_PAUSE;
      else if (tick) begin
        mcnt[k] = mcnt[k] - 1;
        if (mcnt[k] == 0) begin ms[k] = M_DONE; d = 1'b1; end
      end
    end else if (load) begin
      if (legal) begin mcnt[k] = preset; msaved[k] = preset; ms[k] = M_IDLE; end
      else le = 1'b1;
    end else if (ms[k] != M_DONE) begin
      if (start && mcnt[k] != 0) ms[k] = M_RUN;
    end else if (mauto[k] && msaved[k] != 0) begin
      mcnt[k] = msaved[k];
      ms[k]   = M_RUN;
    end
    mins   = mcnt[k] / 60;
    secs   = mcnt[k] % 60;
    e.mt   = 4'(mins / 10);
    e.mu   = 4'(mins % 10);
    e.st   = 4'(secs / 10);
    e.su   = 4'(secs % 10);
    e.run  = (ms[k] == M_RUN);
    e.done = d;
    e.lerr = le;
  endtask

  // Queue the expectation for the coming edge, then hand the cycle to the DUT.
  task automatic step();
    exp_t e0, e1;
    step_model(0, e0);
    step_model(1, e1);
    q0.push_back(e0);
    q1.push_back(e1);
    @(negedge clk);
  endtask

  task automatic cyc(input bit c, input bit t, input bit l, input bit s, input bit p);
    cr = c; tick = t; load = l; start = s; pause = p;
    step();
  endtask

  task automatic setp(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
    pre_m_t = a; pre_m_u = b; pre_s_t = c; pre_s_u = d;
  endtask

  task automatic cmp(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s txn=%0d actual=%0d required=%0d", nm, txn, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e0, e1;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0 && q1.size() > 0) begin
        e0 = q0.pop_front();
        e1 = q1.pop_front();
        cmp("d0.bcd_m_t", int'(mt0), int'(e0.mt));
        cmp("d0.bcd_m_u", int'(mu0), int'(e0.mu));
        cmp("d0.bcd_s_t", int'(st0), int'(e0.st));
        cmp("d0.bcd_s_u", int'(su0), int'(e0.su));
        cmp("d0.running", int'(run0), int'(e0.run));
        cmp("d0.done", int'(done0), int'(e0.done));
        cmp("d0.load_err", int'(lerr0), int'(e0.lerr));
        cmp("d1.bcd_m_t", int'(mt1), int'(e1.mt));
        cmp("d1.bcd_m_u", int'(mu1), int'(e1.mu));
        cmp("d1.bcd_s_t", int'(st1), int'(e1.st));
        cmp("d1.bcd_s_u", int'(su1), int'(e1.su));
        cmp("d1.running", int'(run1), int'(e1.run));
        cmp("d1.done", int'(done1), int'(e1.done));
        cmp("d1.load_err", int'(lerr1), int'(e1.lerr));
        $display("txn %0d d0=%h%h:%h%h run=%0b done=%0b err=%0b d1=%h%h:%h%h run=%0b done=%0b err=%0b",
                 txn, mt0, mu0, st0, su0, run0, done0, lerr0, mt1, mu1, st1, su1, run1, done1, lerr1);
        txn++;
      end
    end
  end

  initial begin : driver
    // Reset, then 01:05 counted through the minutes borrow.
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 1, 1, 0);
    setp(4'd0, 4'd1, 4'd0, 4'd5);
    cyc(1, 0, 1, 0, 0);
    cyc(1, 1, 0, 1, 0);
    repeat (6) cyc(1, 1, 0, 0, 0);
    // 00:02 down to zero, done pulse, ticks held at zero.
    setp(4'd0, 4'd0, 4'd0, 4'd2);
    cyc(1, 0, 1, 0, 0);
    cyc(1, 0, 0, 1, 0);
    repeat (4) cyc(1, 1, 0, 0, 0);
    // Illegal seconds tens, then a load ignored in RUN.
    setp(4'd0, 4'd0, 4'd6, 4'd0);
    cyc(1, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0);
    setp(4'd0, 4'd1, 4'd0, 4'd0);
    cyc(1, 0, 1, 1, 0);
    cyc(1, 0, 0, 1, 0);
    setp(4'd1, 4'd2, 4'd3, 4'd4);
    cyc(1, 1, 1, 0, 0);
    cyc(1, 0, 1, 0, 0);
    // Pause with tick in the same cycle, frozen ticks, resume.
    cyc(1, 0, 0, 0, 1);
    setp(4'd0, 4'd5, 4'd0, 4'd0);
    cyc(1, 0, 1, 0, 0);
    cyc(1, 1, 0, 1, 0);
    cyc(1, 1, 0, 0, 1);
    repeat (3) cyc(1, 1, 0, 0, 0);
    cyc(1, 0, 0, 1, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 1);
    // Minutes-tens limit: 6 is legal only on dut0, 9x on dut0, A on neither.
    setp(4'd6, 4'd0, 4'd0, 4'd0);
    cyc(1, 0, 1, 0, 0);
    setp(4'd10, 4'd0, 4'd0, 4'd0);
    cyc(1, 0, 1, 0, 0);
    // 00:03 run to done; dut1 reloads after one DONE cycle.
    setp(4'd0, 4'd0, 4'd0, 4'd3);
    cyc(1, 0, 1, 0, 0);
    cyc(1, 0, 0, 1, 0);
    repeat (3) cyc(1, 1, 0, 0, 0);
    repeat (3) cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 1);
    // 42:17 in RUN, clear overrides everything, start at zero ignored.
    setp(4'd4, 4'd2, 4'd1, 4'd7);
    cyc(1, 0, 1, 0, 0);
    cyc(1, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 1, 1, 0);
    cyc(1, 0, 0, 1, 0);
    cyc(1, 1, 0, 0, 0);

    // Random phase.
    for (int i = 0; i < 1500; i++) begin
      cr    = ($urandom_range(0, 99) != 0);
      tick  = 1'($urandom_range(0, 1));
      load  = ($urandom_range(0, 15) == 0);
      start = ($urandom_range(0, 7) == 0);
      pause = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 3) == 0) begin
        setp(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
             4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      end else begin
        setp(4'd0, 4'($urandom_range(0, 1)), 4'($urandom_range(0, 5)), 4'($urandom_range(0, 9)));
      end
      step();
    end
    cyc(1, 0, 0, 0, 0);

    @(posedge clk);
    #2;
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", q0.size() + q1.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
